draw_scheduler: RTL and testbench
=================================

Name: draw_scheduler

Overview:
- Sequences all framebuffer writes for one game step and shares the single VGA pixel-write port between three drawers: screen clear, snake body, food.
- Each drawer has a start/done handshake. The scheduler starts drawers in a fixed order, muxes the active drawer's coordinates and colour onto the write port, and reports step completion to game logic.
- Sits between the game-step logic and the VGA framebuffer writer. Replaces ad-hoc write_done-based muxing.

Parameters:
- X_W, 10, x coordinate width.
- Y_W, 9, y coordinate width.
- TIMEOUT, 400000, max cycles a drawer may stay busy before abort.
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse requesting a game-step redraw.
- dead  in  1  game-over level.
- clr_start  out  1  one-cycle start pulse to the clear drawer.
- clr_valid  in  1  clear drawer presents a pixel.
- clr_x  in  X_W  clear drawer x coordinate.
- clr_y  in  Y_W  clear drawer y coordinate.
- clr_done  in  1  clear drawer finished (one-cycle pulse).
- snk_start  out  1  one-cycle start pulse to the snake drawer.
- snk_valid  in  1  snake drawer presents a pixel.
- snk_x  in  X_W  snake drawer x coordinate.
- snk_y  in  Y_W  snake drawer y coordinate.
- snk_color  in  1  snake drawer pixel colour.
- snk_done  in  1  snake drawer finished (one-cycle pulse).
- food_start  out  1  one-cycle start pulse to the food drawer.
- food_valid  in  1  food drawer presents a pixel.
- food_x  in  X_W  food drawer x coordinate.
- food_y  in  Y_W  food drawer y coordinate.
- food_color  in  1  food drawer pixel colour.
- food_done  in  1  food drawer finished (one-cycle pulse).
- x  out  X_W  framebuffer write x.
- y  out  Y_W  framebuffer write y.
- pixel_color  out  1  framebuffer write colour.
- pixel_write  out  1  framebuffer write enable.
- busy  out  1  high in any state other than IDLE.
- step_done  out  1  one-cycle pulse when a full step has been drawn.
- timeout_err  out  1  sticky; set when any drawer times out.
- overrun_cnt  out  OVR_W  saturating count of dropped frame_ticks.

Behaviour:
- Reset (async): state IDLE, clear_pending=1, tick_pending=0, dead_q=0. All start pulses, step_done, pixel_write, x, y and pixel_color are 0. timeout_err=0, overrun_cnt=0.
- States: IDLE, CLEAR, SNAKE, FOOD, FINISH.
- IDLE priority:
  - clear_pending=1 → CLEAR, with clr_start pulsed on the transition cycle.
  - else (frame_tick or tick_pending) and dead=0 → SNAKE, with snk_start pulsed and tick_pending cleared.
  - else stay in IDLE.
- CLEAR: port muxed from the clear drawer; pixel_color = dead (white screen on game over, black otherwise). On clr_done: clear_pending←0, go to IDLE.
- SNAKE: port muxed from the snake drawer. On snk_done → FOOD, with food_start pulsed.
- FOOD: port muxed from the food drawer. On food_done → FINISH.
- FINISH: step_done=1 for exactly one cycle, then IDLE.
- Write-port mux is combinational from the state register: zero latency from drawer signals to x/y/pixel_color/pixel_write. pixel_write equals the active drawer's valid. In IDLE and FINISH, pixel_write=0 and x=y=pixel_color=0.
- Start pulses are registered and issued in the cycle the new state is entered. The drawer's first valid may follow one or more cycles later.
- A done input is honoured only in its matching state. Stray dones are ignored.
- frame_tick while busy:
  - if tick_pending=0, set it (one-deep queue);
  - otherwise overrun_cnt increments, saturating at 2^OVR_W−1.
  - A frame_tick arriving in the same cycle IDLE consumes a pending tick counts as a new pending tick.
- dead:
  - A rising edge (dead_q=0, dead=1) sets clear_pending. It takes effect at the next IDLE; the current sequence is not aborted.
  - While dead=1, frame_tick is ignored: not queued, not counted.
  - A falling edge of dead sets clear_pending, so a black clear runs before play resumes.
- Watchdog:
  - Counter resets on every state change and runs in CLEAR, SNAKE and FOOD.
  - When it reaches TIMEOUT−1 without the expected done: go to IDLE, set timeout_err (cleared only by reset).
  - On a CLEAR timeout, clear_pending stays set, so the clear retries.
  - On a SNAKE or FOOD timeout, step_done is not pulsed.
- Reset mid-sequence returns to IDLE immediately. No start pulse is emitted during reset.

Decomposition:
- draw_pkg holds:
  - sched_state_t enum (IDLE, CLEAR, SNAKE, FOOD, FINISH);
  - constants X_W_DEF=10, Y_W_DEF=9, COLOR_BLACK=0, COLOR_WHITE=1.
- One sub-module, draw_watchdog:
  - parameter TIMEOUT; inputs clk, reset, restart, enable; output expired (one cycle);
  - counter width $clog2(TIMEOUT).

Test Plan:
- Reset release with no ticks → clr_start pulse in cycle 1 after reset deassert. Clear pixels pass through with pixel_color=0. clr_done → IDLE, busy=0, no step_done.
- frame_tick in IDLE → snk_start next cycle. Snake pixel (x=100, y=50, color=1, valid=1) appears on the port the same cycle. snk_done → food_start. food_done → step_done exactly 1 cycle later, then busy=0.
- Three frame_ticks during SNAKE → tick_pending set, overrun_cnt=2. After FINISH, SNAKE restarts without a new tick.
- dead rises mid-FOOD → FOOD completes, step_done pulses, then CLEAR with pixel_color=1. Ticks while dead=1 → overrun_cnt unchanged, no snk_start. dead falls → second CLEAR with pixel_color=0.
- Snake drawer never asserts done, TIMEOUT=16 → after 16 cycles in SNAKE: IDLE, timeout_err=1, no step_done. A later tick still starts SNAKE.
- Async reset asserted mid-CLEAR, between clock edges → outputs zero immediately. After release, CLEAR reruns (clr_start pulse) and timeout_err=0.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and constants for the framebuffer draw scheduler.
package draw_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SNAKE  = 3'd2,
        FOOD   = 3'd3,
        FINISH = 3'd4
    } sched_state_t;

    localparam int   X_W_DEF     = 10;
    localparam int   Y_W_DEF     = 9;
    localparam logic COLOR_BLACK = 1'b0;
    localparam logic COLOR_WHITE = 1'b1;

    // Screen goes white on game over, black otherwise.
    function automatic logic clear_color(input logic dead);
        return dead ? COLOR_WHITE : COLOR_BLACK;
    endfunction

endpackage

// File: rtl/draw_watchdog.sv
// Busy-time watchdog: counts enabled cycles since the last restart and flags
// the cycle in which the count reaches TIMEOUT-1.
module draw_watchdog #(
    parameter int TIMEOUT = 400000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Cycle counter, cleared on every state change and held once it hits the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (restart) begin
            cnt_r <= '0;
        end else if (enable && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = enable && (cnt_r == LAST);

endmodule

// File: rtl/draw_scheduler.sv
// Sequences clear/snake/food drawers for one game step and shares the single
// framebuffer write port between them.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int X_W     = X_W_DEF,
    parameter int Y_W     = Y_W_DEF,
    parameter int TIMEOUT = 400000,
    parameter int OVR_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             dead,
    output logic             clr_start,
    input  logic             clr_valid,
    input  logic [X_W-1:0]   clr_x,
    input  logic [Y_W-1:0]   clr_y,
    input  logic             clr_done,
    output logic             snk_start,
    input  logic             snk_valid,
    input  logic [X_W-1:0]   snk_x,
    input  logic [Y_W-1:0]   snk_y,
    input  logic             snk_color,
    input  logic             snk_done,
    output logic             food_start,
    input  logic             food_valid,
    input  logic [X_W-1:0]   food_x,
    input  logic [Y_W-1:0]   food_y,
    input  logic             food_color,
    input  logic             food_done,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic             pixel_color,
    output logic             pixel_write,
    output logic             busy,
    output logic             step_done,
    output logic             timeout_err,
    output logic [OVR_W-1:0] overrun_cnt
);

    localparam logic [OVR_W-1:0] OVR_MAX = '1;
    localparam logic [OVR_W-1:0] OVR_ONE = OVR_W'(1);

    sched_state_t     state_r, state_next_s;
    logic             clear_pending_r, tick_pending_r, dead_q_r;
    logic             clr_start_r, snk_start_r, food_start_r;
    logic             clr_start_next_s, snk_start_next_s, food_start_next_s;
    logic             launch_s, clr_ack_s, timeout_hit_s;
    logic             wd_expired_s, wd_enable_s, wd_restart_s;
    logic             timeout_err_r;
    logic [OVR_W-1:0] overrun_r;

    assign wd_enable_s  = (state_r == CLEAR) || (state_r == SNAKE) || (state_r == FOOD);
    assign wd_restart_s = (state_next_s != state_r);

    draw_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .restart (wd_restart_s),
        .enable  (wd_enable_s),
        .expired (wd_expired_s)
    );

    // State register and registered start pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            clr_start_r  <= 1'b0;
            snk_start_r  <= 1'b0;
            food_start_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            clr_start_r  <= clr_start_next_s;
            snk_start_r  <= snk_start_next_s;
            food_start_r <= food_start_next_s;
        end
    end

    // Next-state logic; a done always wins over a coincident watchdog expiry.
    always_comb begin
        state_next_s      = state_r;
        clr_start_next_s  = 1'b0;
        snk_start_next_s  = 1'b0;
        food_start_next_s = 1'b0;
        launch_s          = 1'b0;
        clr_ack_s         = 1'b0;
        timeout_hit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear_pending_r) begin
                    state_next_s     = CLEAR;
                    clr_start_next_s = 1'b1;
                end else if ((frame_tick || tick_pending_r) && !dead) begin
                    state_next_s     = SNAKE;
                    snk_start_next_s = 1'b1;
                    launch_s         = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CLEAR: begin
                if (clr_done) begin
                    state_next_s = IDLE;
                    clr_ack_s    = 1'b1;
                end else if (wd_expired_s) begin
                    state_next_s  = IDLE;
                    timeout_hit_s = 1'b1;
                end else begin
                    state_next_s = CLEAR;
                end
            end
            SNAKE: begin
                if (snk_done) begin
                    state_next_s      = FOOD;
                    food_start_next_s = 1'b1;
                end else if (wd_expired_s) begin
                    state_next_s  = IDLE;
                    timeout_hit_s = 1'b1;
                end else begin
                    state_next_s = SNAKE;
                end
            end
            FOOD: begin
                if (food_done) begin
                    state_next_s = FINISH;
                end else if (wd_expired_s) begin
                    state_next_s  = IDLE;
                    timeout_hit_s = 1'b1;
                end else begin
                    state_next_s = FOOD;
                end
            end
            FINISH:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Pending clear/tick bookkeeping, overrun counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clear_pending_r <= 1'b1;
            tick_pending_r  <= 1'b0;
            dead_q_r        <= 1'b0;
            overrun_r       <= '0;
            timeout_err_r   <= 1'b0;
        end else begin
            dead_q_r <= dead;
            if (dead != dead_q_r) begin
                clear_pending_r <= 1'b1;
            end else if (clr_ack_s) begin
                clear_pending_r <= 1'b0;
            end else begin
                clear_pending_r <= clear_pending_r;
            end
            // A tick coinciding with consumption of a pending tick re-queues.
            if (launch_s) begin
                tick_pending_r <= tick_pending_r && frame_tick;
            end else if (frame_tick && !dead) begin
                if (!tick_pending_r) begin
                    tick_pending_r <= 1'b1;
                end else if (overrun_r != OVR_MAX) begin
                    overrun_r <= overrun_r + OVR_ONE;
                end else begin
                    overrun_r <= overrun_r;
                end
            end else begin
                tick_pending_r <= tick_pending_r;
            end
            timeout_err_r <= timeout_err_r || timeout_hit_s;
        end
    end

    // Zero-latency write-port mux selected by the state register.
    always_comb begin
        x           = '0;
        y           = '0;
        pixel_color = COLOR_BLACK;
        pixel_write = 1'b0;
        case (state_r)
            CLEAR: begin
                x           = clr_x;
                y           = clr_y;
                pixel_color = clear_color(dead);
                pixel_write = clr_valid;
            end
            SNAKE: begin
                x           = snk_x;
                y           = snk_y;
                pixel_color = snk_color;
                pixel_write = snk_valid;
            end
            FOOD: begin
                x           = food_x;
                y           = food_y;
                pixel_color = food_color;
                pixel_write = food_valid;
            end
            default: begin
                x           = '0;
                y           = '0;
                pixel_color = COLOR_BLACK;
                pixel_write = 1'b0;
            end
        endcase
    end

    assign clr_start   = clr_start_r;
    assign snk_start   = snk_start_r;
    assign food_start  = food_start_r;
    assign busy        = (state_r != IDLE);
    assign step_done   = (state_r == FINISH);
    assign timeout_err = timeout_err_r;
    assign overrun_cnt = overrun_r;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: pixel scoreboard plus handshake checks.
module tb_draw_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0, dead = 1'b0;
    logic       clr_start, snk_start, food_start;
    logic       clr_valid = 1'b0, clr_done = 1'b0;
    logic [9:0] clr_x = '0;
    logic [8:0] clr_y = '0;
    logic       snk_valid = 1'b0, snk_color = 1'b0, snk_done = 1'b0;
    logic [9:0] snk_x = '0;
    logic [8:0] snk_y = '0;
    logic       food_valid = 1'b0, food_color = 1'b0, food_done = 1'b0;
    logic [9:0] food_x = '0;
    logic [8:0] food_y = '0;
    logic [9:0] x;
    logic [8:0] y;
    logic       pixel_color, pixel_write, busy, step_done, timeout_err;
    logic [7:0] overrun_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int n_step = 0;
    int step_snap;
    logic [20:0] exp_q[$];

    draw_scheduler #(.X_W(10), .Y_W(9), .TIMEOUT(16), .OVR_W(8)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .dead(dead),
        .clr_start(clr_start), .clr_valid(clr_valid), .clr_x(clr_x), .clr_y(clr_y), .clr_done(clr_done),
        .snk_start(snk_start), .snk_valid(snk_valid), .snk_x(snk_x), .snk_y(snk_y),
        .snk_color(snk_color), .snk_done(snk_done),
        .food_start(food_start), .food_valid(food_valid), .food_x(food_x), .food_y(food_y),
        .food_color(food_color), .food_done(food_done),
        .x(x), .y(y), .pixel_color(pixel_color), .pixel_write(pixel_write),
        .busy(busy), .step_done(step_done), .timeout_err(timeout_err), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (step_done) n_step <= n_step + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present one pixel from drawer src, queue the expected port value, compare.
    task automatic drive_px(input int src, input logic [9:0] px, input logic [8:0] py,
                            input logic pc, input logic exp_c);
        logic [20:0] e;
        case (src)
            0: begin clr_valid = 1'b1; clr_x = px; clr_y = py; end
            1: begin snk_valid = 1'b1; snk_x = px; snk_y = py; snk_color = pc; end
            default: begin food_valid = 1'b1; food_x = px; food_y = py; food_color = pc; end
        endcase
        exp_q.push_back({1'b1, px, py, exp_c});
        #1;
        e = exp_q.pop_front();
        chk("pixel", {11'd0, pixel_write, x, y, pixel_color}, {11'd0, e});
        clr_valid = 1'b0; snk_valid = 1'b0; food_valid = 1'b0;
    endtask

    task automatic finish_step();
        snk_done = 1'b1; step(); snk_done = 1'b0;
        food_done = 1'b1; step(); food_done = 1'b0;
        step();
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_starts", {clr_start, snk_start, food_start}, 3'b000);
        chk("rst_port", {pixel_write, x, y, pixel_color}, 21'd0);
        chk("rst_err_ovr", {timeout_err, overrun_cnt}, 9'd0);
        reset = 1'b0;

        // Power-on clear
        step();
        chk("por_clr_start", clr_start, 1'b1);
        chk("por_busy", busy, 1'b1);
        step();
        chk("por_clr_start_once", clr_start, 1'b0);
        drive_px(0, 10'd5, 9'd7, 1'b1, 1'b0);
        clr_done = 1'b1; step(); clr_done = 1'b0;
        chk("por_idle", busy, 1'b0);
        chk("por_no_step", step_done, 1'b0);

        // Stray done in IDLE is ignored
        snk_done = 1'b1; step(); snk_done = 1'b0;
        chk("stray_done", {busy, food_start}, 2'b00);

        // Normal step
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("snk_start", snk_start, 1'b1);
        drive_px(1, 10'd100, 9'd50, 1'b1, 1'b1);
        snk_done = 1'b1; step(); snk_done = 1'b0;
        chk("food_start", food_start, 1'b1);
        drive_px(2, 10'd3, 9'd4, 1'b0, 1'b0);
        food_done = 1'b1; step(); food_done = 1'b0;
        chk("step_done", step_done, 1'b1);
        step();
        chk("step_done_once", {step_done, busy}, 2'b00);

        // Queued and overrun ticks
        frame_tick = 1'b1; step();
        step(); step(); step();
        frame_tick = 1'b0;
        chk("overrun2", overrun_cnt, 8'd2);
        snk_done = 1'b1; step(); snk_done = 1'b0;
        food_done = 1'b1; step(); food_done = 1'b0;
        chk("step_done2", step_done, 1'b1);
        step();
        chk("idle_between", busy, 1'b0);
        step();
        chk("pending_restart", snk_start, 1'b1);
        finish_step();
        chk("pending_cleared", busy, 1'b0);

        // Game over during FOOD
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        snk_done = 1'b1; step(); snk_done = 1'b0;
        dead = 1'b1; step();
        food_done = 1'b1; step(); food_done = 1'b0;
        chk("dead_step_done", step_done, 1'b1);
        step(); step();
        chk("dead_clr_start", clr_start, 1'b1);
        drive_px(0, 10'd639, 9'd479, 1'b0, 1'b1);
        frame_tick = 1'b1; step(); step(); frame_tick = 1'b0;
        chk("dead_ovr_same", overrun_cnt, 8'd2);
        clr_done = 1'b1; step(); clr_done = 1'b0;
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("dead_no_snake", {busy, snk_start}, 2'b00);
        dead = 1'b0; step(); step();
        chk("revive_clr_start", clr_start, 1'b1);
        drive_px(0, 10'd1, 9'd2, 1'b1, 1'b0);
        clr_done = 1'b1; step(); clr_done = 1'b0;
        chk("revive_idle", busy, 1'b0);

        // Snake watchdog timeout
        step_snap = n_step;
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("wd_still_snake", {busy, timeout_err}, 2'b10);
        step();
        chk("wd_abort", {busy, timeout_err}, 2'b01);
        chk("wd_no_step", n_step, step_snap);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("wd_restart", {snk_start, timeout_err}, 2'b11);
        finish_step();
        chk("total_steps", n_step, 32'd5);

        // Async reset mid-CLEAR
        dead = 1'b1; step(); step();
        chk("rst_clr_enter", clr_start, 1'b1);
        clr_valid = 1'b1; clr_x = 10'd77; clr_y = 9'd33;
        #1;
        chk("pre_rst_write", {pixel_write, x, pixel_color}, {1'b1, 10'd77, 1'b1});
        #1 reset = 1'b1;
        #1;
        chk("async_rst_port", {pixel_write, x, y, pixel_color}, 21'd0);
        chk("async_rst_busy", {busy, timeout_err, clr_start}, 3'b000);
        clr_valid = 1'b0; dead = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("post_rst_clr", {clr_start, timeout_err}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
